// File: rtl/isp_mosaic_if.sv
// isp_mosaic_if: pixel-stream bundle for isp_mosaic.
//   in_*      : RGB input stream (href/vsync/de timing plus r/g/b components)
//   bayer_sel : runtime CFA pattern (0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR)
//   err_clr   : clears the sticky geometry flags
//   out_*     : Bayer raw output stream, timing delayed 2 cycles
//   err_*     : sticky geometry flags
// master = stream source / controller, slave = isp_mosaic.
interface isp_mosaic_if #(
  parameter int BITS = 8
);
  logic            in_href;
  logic            in_vsync;
  logic            in_de;
  logic [BITS-1:0] in_r;
  logic [BITS-1:0] in_g;
  logic [BITS-1:0] in_b;
  logic [1:0]      bayer_sel;
  logic            err_clr;
  logic            out_href;
  logic            out_vsync;
  logic            out_de;
  logic [BITS-1:0] out_raw;
  logic            err_width;
  logic            err_height;

  modport master (
    output in_href, in_vsync, in_de, in_r, in_g, in_b, bayer_sel, err_clr,
    input  out_href, out_vsync, out_de, out_raw, err_width, err_height
  );

  modport slave (
    input  in_href, in_vsync, in_de, in_r, in_g, in_b, bayer_sel, err_clr,
    output out_href, out_vsync, out_de, out_raw, err_width, err_height
  );
endinterface

// File: rtl/isp_mosaic.sv
// isp_mosaic: re-mosaics an RGB pixel stream into a single-channel Bayer raw
// stream (loopback / reference path for isp_demosaic).
//   pclk  : pixel clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : isp_mosaic_if.slave (RGB in, raw out, pattern select, error flags)
// Two register stages: stage 1 holds the selected component (0 outside href),
// stage 2 is the output register. All timing signals ride the same pipeline.
// Optional geometry checker built when ISP_MOSAIC_CHECK_EN is defined;
// otherwise err_width/err_height are tied low and err_clr is ignored.
module isp_mosaic #(
  parameter int         BITS   = 8,
  parameter int         WIDTH  = 1280,
  parameter int         HEIGHT = 960,
  parameter logic [1:0] BAYER  = 2'd0
) (
  input  logic          pclk,
  input  logic          rst_n,
  isp_mosaic_if.slave   bus
);

  logic            href_prev_q, href_prev_d;
  logic            vsync_prev_q, vsync_prev_d;
  logic [1:0]      pattern_q, pattern_d;
  logic            pix0_q, pix0_d;
  logic            line0_q, line0_d;
  logic [2:0]      s1_sync_q, s1_sync_d;   // {href, vsync, de}
  logic [2:0]      s2_sync_q, s2_sync_d;
  logic [BITS-1:0] s1_raw_q, s1_raw_d;
  logic [BITS-1:0] s2_raw_q, s2_raw_d;
  logic            vsync_rise, href_fall, line0_cur;
  logic [1:0]      fmt;

  always_comb begin
    vsync_rise   = bus.in_vsync & ~vsync_prev_q;
    href_fall    = href_prev_q & ~bus.in_href;
    href_prev_d  = bus.in_href;
    vsync_prev_d = bus.in_vsync;
    // Pattern only changes at frame start so a frame is never mixed.
    pattern_d    = vsync_rise ? bus.bayer_sel : pattern_q;
    // pix0_q is the phase of the pixel presented this cycle.
    pix0_d       = bus.in_href ? ~pix0_q : 1'b0;
    // vsync overrides a simultaneous href fall.
    line0_d      = bus.in_vsync ? 1'b0 : (href_fall ? ~line0_q : line0_q);
    line0_cur    = bus.in_vsync ? 1'b0 : line0_q;
    fmt          = pattern_q ^ {line0_cur, pix0_q};
    s1_raw_d     = '0;
    if (bus.in_href) begin
      case (fmt)
        2'd0:    s1_raw_d = bus.in_r;
        2'd3:    s1_raw_d = bus.in_b;
        default: s1_raw_d = bus.in_g;
      endcase
    end
    s1_sync_d = {bus.in_href, bus.in_vsync, bus.in_de};
    s2_sync_d = s1_sync_q;
    s2_raw_d  = s1_raw_q;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      href_prev_q  <= 1'b0;
      vsync_prev_q <= 1'b0;
      pattern_q    <= BAYER;
      pix0_q       <= 1'b0;
      line0_q      <= 1'b0;
      s1_sync_q    <= '0;
      s2_sync_q    <= '0;
      s1_raw_q     <= '0;
      s2_raw_q     <= '0;
    end else begin
      href_prev_q  <= href_prev_d;
      vsync_prev_q <= vsync_prev_d;
      pattern_q    <= pattern_d;
      pix0_q       <= pix0_d;
      line0_q      <= line0_d;
      s1_sync_q    <= s1_sync_d;
      s2_sync_q    <= s2_sync_d;
      s1_raw_q     <= s1_raw_d;
      s2_raw_q     <= s2_raw_d;
    end
  end

  assign bus.out_href  = s2_sync_q[2];
  assign bus.out_vsync = s2_sync_q[1];
  assign bus.out_de    = s2_sync_q[0];
  assign bus.out_raw   = s2_raw_q;

`ifdef ISP_MOSAIC_CHECK_EN
  localparam int PW = $clog2(WIDTH + 1);
  localparam int LW = $clog2(HEIGHT + 1);

  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [LW-1:0] line_cnt_q, line_cnt_d;
  logic          seen_vs_q, seen_vs_d;
  logic          err_w_q, err_w_d;
  logic          err_h_q, err_h_d;

  always_comb begin
    pix_cnt_d = pix_cnt_q;
    if (bus.in_href) begin
      // First href-high cycle restarts the count at one.
      if (!href_prev_q)          pix_cnt_d = PW'(1);
      else if (pix_cnt_q != '1)  pix_cnt_d = pix_cnt_q + PW'(1);
    end
    line_cnt_d = line_cnt_q;
    if (vsync_rise)                       line_cnt_d = '0;
    else if (href_fall && line_cnt_q != '1) line_cnt_d = line_cnt_q + LW'(1);
    seen_vs_d = seen_vs_q | vsync_rise;
    err_w_d   = err_w_q | (href_fall && pix_cnt_q != PW'(WIDTH));
    err_h_d   = err_h_q | (vsync_rise && seen_vs_q && line_cnt_q != LW'(HEIGHT));
    if (bus.err_clr) begin
      err_w_d = 1'b0;
      err_h_d = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      seen_vs_q  <= 1'b0;
      err_w_q    <= 1'b0;
      err_h_q    <= 1'b0;
    end else begin
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      seen_vs_q  <= seen_vs_d;
      err_w_q    <= err_w_d;
      err_h_q    <= err_h_d;
    end
  end

  assign bus.err_width  = err_w_q;
  assign bus.err_height = err_h_q;
`else
  localparam int unused_geom = WIDTH + HEIGHT;
  logic unused_clr;
  assign unused_clr     = bus.err_clr;
  assign bus.err_width  = 1'b0;
  assign bus.err_height = 1'b0;
`endif

endmodule
